// File: rtl/multi_ch_log_pkg.sv
`default_nettype none
// ============================================================================
// Module  : multi_ch_log_pkg
// Brief   : Shared types, constants and helpers for the multi-channel log.
// Revision: 1.0 - initial release
// ============================================================================
package multi_ch_log_pkg;

    localparam int DROP_CNT_W     = 32;
    localparam int PKG_CH_W       = 4;     // tag width for the widest (16-channel) build
    localparam int PKG_LOG_DATA_W = 64;

    typedef struct packed {
        logic [PKG_CH_W-1:0]       ch_id;
        logic [PKG_LOG_DATA_W-1:0] record;
    } log_entry_struct;

    function automatic int calc_ch_w(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_ch_stats_log_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Round-robin arbiter; priority starts after the last granted channel.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter
    import multi_ch_log_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = calc_ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_advance,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [CH_W-1:0]   o_gnt_idx
);

    logic [CH_W-1:0] r_ptr;
    logic [CH_W-1:0] w_nxt_ptr;
    logic [CH_W-1:0] w_j;
    logic            w_found;
    int              w_int;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_nxt_ptr = r_ptr;
        w_found   = 1'b0;
        w_int     = 0;
        w_j       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_int = (int'(r_ptr) + i) % NUM_CH;
            w_j   = CH_W'(w_int);
            if (!w_found && i_req[w_j]) begin
                w_found   = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_gnt_idx = w_j;
                w_nxt_ptr = (w_int == NUM_CH - 1) ? '0 : CH_W'(w_int + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= w_nxt_ptr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_ch_stats_log_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module  : sdp_ram
// Brief   : Simple dual-port synchronous RAM, read-first on address collision.
// Revision: 1.0 - initial release
// ============================================================================
module sdp_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Only the output register is reset so the response bus starts at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/multi_ch_stats_log.sv
`default_nettype none
// ============================================================================
// Module  : multi_ch_stats_log
// Brief   : Round-robin merge of NUM_CH recorder channels into one circular log.
// Revision: 1.0 - initial release
// ============================================================================
module multi_ch_stats_log
    import multi_ch_log_pkg::*;
#(
    parameter  int NUM_CH         = 4,
    parameter  int LOG_DATA_W     = 64,
    parameter  int MEM_DEPTH_LOG2 = 10,
    parameter  int WRAP_MODE      = 1,
    localparam int CH_W           = calc_ch_w(NUM_CH),
    localparam int ENTRY_W        = CH_W + LOG_DATA_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            wr_req_val,
    input  logic [NUM_CH*LOG_DATA_W-1:0] wr_req_data,
    input  logic                         log_clr,
    input  logic                         rd_req_val,
    input  logic [MEM_DEPTH_LOG2-1:0]    rd_req_addr,
    output logic                         rd_req_rdy,
    output logic                         rd_resp_val,
    output logic [ENTRY_W-1:0]           rd_resp_data,
    input  logic                         rd_resp_rdy,
    output logic [MEM_DEPTH_LOG2-1:0]    curr_wr_addr,
    output logic                         log_has_wrapped,
    output logic                         log_full,
    output logic [DROP_CNT_W-1:0]        drop_cnt
);

    logic [NUM_CH-1:0]         r_pend;
    logic [LOG_DATA_W-1:0]     r_hold [NUM_CH];
    logic [NUM_CH-1:0]         w_arb_req;
    logic [NUM_CH-1:0]         w_gnt;
    logic [NUM_CH-1:0]         w_drop;
    logic [CH_W-1:0]           w_gnt_idx;
    logic                      w_wr_en;
    logic [MEM_DEPTH_LOG2-1:0] r_wr_addr;
    logic                      r_wrapped;
    logic                      r_full;
    logic [DROP_CNT_W-1:0]     r_drop_cnt;
    logic [DROP_CNT_W:0]       w_drop_sum;
    logic                      r_rd_resp_val;
    logic                      w_rd_accept;

    // A full stop-mode log freezes arbitration so pending records stay held.
    assign w_arb_req = r_full ? '0 : r_pend;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (log_clr),
        .i_req     (w_arb_req),
        .i_advance (w_wr_en),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_wr_en    = (|w_gnt) && !log_clr;
    assign w_drop     = wr_req_val & r_pend & ~w_gnt & {NUM_CH{!log_clr}};
    assign w_drop_sum = {1'b0, r_drop_cnt} + (DROP_CNT_W + 1)'($countones(w_drop));

    // A granted slot frees this cycle, so a same-cycle write is still captured.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst || log_clr) begin
                r_pend[i] <= 1'b0;
            end else if (wr_req_val[i] && (!r_pend[i] || w_gnt[i])) begin
                r_pend[i] <= 1'b1;
                r_hold[i] <= wr_req_data[i*LOG_DATA_W +: LOG_DATA_W];
            end else if (w_gnt[i]) begin
                r_pend[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || log_clr) begin
            r_wr_addr  <= '0;
            r_wrapped  <= 1'b0;
            r_full     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_addr <= r_wr_addr + MEM_DEPTH_LOG2'(1);
                if (r_wr_addr == '1) begin
                    r_wrapped <= 1'b1;
                    if (WRAP_MODE == 0) begin
                        r_full <= 1'b1;
                    end
                end
            end
            r_drop_cnt <= w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];
        end
    end

    assign rd_req_rdy  = !r_rd_resp_val || rd_resp_rdy;
    assign w_rd_accept = rd_req_val && rd_req_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_resp_val <= 1'b0;
        end else if (w_rd_accept) begin
            r_rd_resp_val <= 1'b1;
        end else if (rd_resp_rdy) begin
            r_rd_resp_val <= 1'b0;
        end
    end

    sdp_ram #(
        .DATA_W (ENTRY_W),
        .ADDR_W (MEM_DEPTH_LOG2)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_addr),
        .i_wr_data ({w_gnt_idx, r_hold[w_gnt_idx]}),
        .i_rd_en   (w_rd_accept),
        .i_rd_addr (rd_req_addr),
        .o_rd_data (rd_resp_data)
    );

    assign rd_resp_val     = r_rd_resp_val;
    assign curr_wr_addr    = r_wr_addr;
    assign log_has_wrapped = r_wrapped;
    assign log_full        = r_full;
    assign drop_cnt        = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multi_ch_stats_log.sv
`default_nettype none
// ============================================================================
// Module  : tb_multi_ch_stats_log
// Brief   : Directed bench for multi_ch_stats_log (wrap and stop-mode builds).
// Revision: 1.0 - initial release
// ============================================================================
module tb_multi_ch_stats_log;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int EW  = 2 + DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [NCH-1:0]    wv_w, wv_s;
    logic [NCH*DW-1:0] wd_w, wd_s;
    logic              clr_w, clr_s, rqv_w, rqv_s, rqr_w, rqr_s;
    logic [AW-1:0]     rqa_w, rqa_s, addr_w, addr_s;
    logic              rsv_w, rsv_s, rsr_w, rsr_s;
    logic [EW-1:0]     rsd_w, rsd_s;
    logic              wrap_w, wrap_s, full_w, full_s;
    logic [31:0]       drop_w, drop_s;

    multi_ch_stats_log #(.NUM_CH(NCH), .LOG_DATA_W(DW), .MEM_DEPTH_LOG2(AW), .WRAP_MODE(1)) dut_w (
        .clk(clk), .rst(rst), .wr_req_val(wv_w), .wr_req_data(wd_w), .log_clr(clr_w),
        .rd_req_val(rqv_w), .rd_req_addr(rqa_w), .rd_req_rdy(rqr_w), .rd_resp_val(rsv_w),
        .rd_resp_data(rsd_w), .rd_resp_rdy(rsr_w), .curr_wr_addr(addr_w),
        .log_has_wrapped(wrap_w), .log_full(full_w), .drop_cnt(drop_w));

    multi_ch_stats_log #(.NUM_CH(NCH), .LOG_DATA_W(DW), .MEM_DEPTH_LOG2(AW), .WRAP_MODE(0)) dut_s (
        .clk(clk), .rst(rst), .wr_req_val(wv_s), .wr_req_data(wd_s), .log_clr(clr_s),
        .rd_req_val(rqv_s), .rd_req_addr(rqa_s), .rd_req_rdy(rqr_s), .rd_resp_val(rsv_s),
        .rd_resp_data(rsd_s), .rd_resp_rdy(rsr_s), .curr_wr_addr(addr_s),
        .log_has_wrapped(wrap_s), .log_full(full_s), .drop_cnt(drop_s));

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int            addr;
        logic [EW-1:0] exp;
    } rd_vec_t;
    rd_vec_t tab [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] ent(input int ch, input int d);
        return {ch[1:0], d[15:0]};
    endfunction

    task automatic read_chk_w(input string name, input int a, input logic [EW-1:0] exp);
        rqv_w = 1'b1;
        rqa_w = a[AW-1:0];
        tick();
        rqv_w = 1'b0;
        chk({name, "_val"}, 64'(rsv_w), 64'd1);
        chk(name, 64'(rsd_w), 64'(exp));
        tick();
    endtask

    task automatic read_chk_s(input string name, input int a, input logic [EW-1:0] exp);
        rqv_s = 1'b1;
        rqa_s = a[AW-1:0];
        tick();
        rqv_s = 1'b0;
        chk({name, "_val"}, 64'(rsv_s), 64'd1);
        chk(name, 64'(rsd_s), 64'(exp));
        tick();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            tab[i].addr = i;
            tab[i].exp  = ent(i % 4, ((i < 4) ? 'h100 : 'h200) + (i % 4));
        end
        tab[8]  = '{0, ent(1, 'h111)};
        tab[9]  = '{1, ent(2, 'h302)};
        tab[10] = '{2, ent(3, 'h303)};
        tab[11] = '{3, ent(0, 'h300)};
        tab[12] = '{4, ent(1, 'h401)};
        tab[13] = '{5, ent(1, 'h404)};

        rst = 1'b1;
        wv_w = '0; wd_w = '0; clr_w = 1'b0; rqv_w = 1'b0; rqa_w = '0; rsr_w = 1'b1;
        wv_s = '0; wd_s = '0; clr_s = 1'b0; rqv_s = 1'b0; rqa_s = '0; rsr_s = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_rd_req_rdy", 64'(rqr_w), 64'd1);
        chk("rst_rd_resp_val", 64'(rsv_w), 64'd0);
        chk("rst_rd_resp_data", 64'(rsd_w), 64'd0);
        chk("rst_wr_addr", 64'(addr_w), 64'd0);
        chk("rst_wrapped", 64'(wrap_w), 64'd0);
        chk("rst_full", 64'(full_w), 64'd0);
        chk("rst_drop", 64'(drop_w), 64'd0);
        chk("rst_s_full", 64'(full_s), 64'd0);

        // Single channel write then read-back
        wv_w = 4'b0100;
        wd_w[2*DW +: DW] = 16'h00A5;
        tick();
        wv_w = '0;
        chk("single_addr_e0", 64'(addr_w), 64'd0);
        tick();
        chk("single_addr_e1", 64'(addr_w), 64'd1);
        read_chk_w("single_rd", 0, ent(2, 'hA5));

        // All channels in one cycle, twice
        clr_w = 1'b1;
        tick();
        clr_w = 1'b0;
        chk("clr_addr", 64'(addr_w), 64'd0);
        for (int b = 0; b < 2; b++) begin
            wv_w = '1;
            for (int c = 0; c < NCH; c++) wd_w[c*DW +: DW] = 16'(((b == 0) ? 'h100 : 'h200) + c);
            tick();
            wv_w = '0;
            repeat (4) tick();
            chk("burst_addr", 64'(addr_w), 64'(4 * (b + 1)));
        end
        chk("burst_drop", 64'(drop_w), 64'd0);
        for (int i = 0; i < 8; i++) read_chk_w("burst_rd", tab[i].addr, tab[i].exp);

        // Back-to-back writes on channel 1 while 0,2,3 pending (pointer at 2)
        clr_w = 1'b1;
        tick();
        clr_w = 1'b0;
        wv_w = 4'b0010;
        wd_w[1*DW +: DW] = 16'h0111;
        tick();
        wv_w = '0;
        tick();
        wv_w = 4'b1101;
        wd_w[0*DW +: DW] = 16'h0300;
        wd_w[2*DW +: DW] = 16'h0302;
        wd_w[3*DW +: DW] = 16'h0303;
        tick();
        for (int k = 1; k <= 4; k++) begin
            wv_w = 4'b0010;
            wd_w[1*DW +: DW] = 16'('h400 + k);
            tick();
        end
        wv_w = '0;
        repeat (4) tick();
        chk("b2b_drop", 64'(drop_w), 64'd2);
        chk("b2b_addr", 64'(addr_w), 64'd6);
        for (int i = 8; i < 14; i++) read_chk_w("b2b_rd", tab[i].addr, tab[i].exp);

        // Wrap mode: 18 records on channel 0
        clr_w = 1'b1;
        tick();
        clr_w = 1'b0;
        for (int k = 0; k < 18; k++) begin
            wv_w = 4'b0001;
            wd_w[0 +: DW] = 16'(k);
            tick();
        end
        wv_w = '0;
        repeat (2) tick();
        chk("wrap_flag", 64'(wrap_w), 64'd1);
        chk("wrap_addr", 64'(addr_w), 64'd2);
        chk("wrap_full", 64'(full_w), 64'd0);
        chk("wrap_drop", 64'(drop_w), 64'd0);
        read_chk_w("wrap_e0", 0, ent(0, 16));
        read_chk_w("wrap_e2", 2, ent(0, 2));

        // Read backpressure
        rsr_w = 1'b0;
        rqv_w = 1'b1;
        rqa_w = 4'd3;
        tick();
        rqa_w = 4'd5;
        for (int c = 0; c < 5; c++) begin
            chk("bp_req_rdy", 64'(rqr_w), 64'd0);
            chk("bp_resp_val", 64'(rsv_w), 64'd1);
            chk("bp_resp_data", 64'(rsd_w), 64'(ent(0, 3)));
            tick();
        end
        rsr_w = 1'b1;
        tick();
        chk("bb_val0", 64'(rsv_w), 64'd1);
        chk("bb_data0", 64'(rsd_w), 64'(ent(0, 5)));
        rqa_w = 4'd6;
        tick();
        chk("bb_val1", 64'(rsv_w), 64'd1);
        chk("bb_data1", 64'(rsd_w), 64'(ent(0, 6)));
        rqa_w = 4'd7;
        tick();
        chk("bb_val2", 64'(rsv_w), 64'd1);
        chk("bb_data2", 64'(rsd_w), 64'(ent(0, 7)));
        rqv_w = 1'b0;
        tick();
        chk("bb_idle", 64'(rsv_w), 64'd0);

        // Stop mode: records 1..20 on channel 0
        for (int k = 1; k <= 20; k++) begin
            wv_s = 4'b0001;
            wd_s[0 +: DW] = 16'(k);
            tick();
        end
        wv_s = '0;
        repeat (3) tick();
        chk("stop_full", 64'(full_s), 64'd1);
        chk("stop_addr", 64'(addr_s), 64'd0);
        chk("stop_wrapped", 64'(wrap_s), 64'd1);
        chk("stop_drop", 64'(drop_s), 64'd3);
        read_chk_s("stop_e0", 0, ent(0, 1));
        read_chk_s("stop_e15", 15, ent(0, 16));

        // Clear with a simultaneous write: both discarded
        clr_s = 1'b1;
        wv_s = 4'b0001;
        wd_s[0 +: DW] = 16'h0055;
        tick();
        clr_s = 1'b0;
        wv_s = '0;
        chk("clr_full", 64'(full_s), 64'd0);
        chk("clr_addr_s", 64'(addr_s), 64'd0);
        chk("clr_wrapped", 64'(wrap_s), 64'd0);
        chk("clr_drop", 64'(drop_s), 64'd0);
        repeat (2) tick();
        chk("clr_discard", 64'(addr_s), 64'd0);
        wv_s = 4'b0001;
        wd_s[0 +: DW] = 16'h0077;
        tick();
        wv_s = '0;
        tick();
        chk("post_clr_addr", 64'(addr_s), 64'd1);
        read_chk_s("post_clr_e0", 0, ent(0, 'h77));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_ch_stats_log.md
# multi_ch_stats_log

Parametrised successor to the single-channel stats log. Takes fire-and-forget log writes from `NUM_CH` independent stats recorders, for example several echo-app instances. It arbitrates them round-robin into one shared circular log memory, tagging each entry with its channel ID. It serves reads through a valid/ready request/response port for the UDP log reader. It adds a stop-when-full mode, a clear command and drop accounting, none of which the single-channel log has.

## Interface
Parameters:
- `NUM_CH`, 4: number of recorder channels, from 1 to 16.
- `LOG_DATA_W`, 64: payload bits per log record.
- `MEM_DEPTH_LOG2`, 10: log depth is `2**MEM_DEPTH_LOG2` entries.
- `WRAP_MODE`, 1: 1 means overwrite the oldest entry; 0 means stop when full.
- Derived: `CH_W = max(1, $clog2(NUM_CH))`; `ENTRY_W = CH_W + LOG_DATA_W`.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset; **synchronous, active-high**.
- `wr_req_val`  in  NUM_CH  per-channel write strobe.
- `wr_req_data`  in  NUM_CH*LOG_DATA_W  per-channel record; channel i occupies bits [i*LOG_DATA_W +: LOG_DATA_W].
- `log_clr`  in  1  one-cycle pulse that empties the log.
- `rd_req_val`  in  1  read request valid.
- `rd_req_addr`  in  MEM_DEPTH_LOG2  entry index to read.
- `rd_req_rdy`  out  1  read request ready.
- `rd_resp_val`  out  1  read response valid.
- `rd_resp_data`  out  ENTRY_W  read response, `{ch_id, record}`.
- `rd_resp_rdy`  in  1  read response ready.
- `curr_wr_addr`  out  MEM_DEPTH_LOG2  next entry index to be written.
- `log_has_wrapped`  out  1  sticky; set once the write pointer has passed the last entry.
- `log_full`  out  1  stop-mode only: all entries written; always 0 when WRAP_MODE=1.
- `drop_cnt`  out  32  saturating count of records lost.

## Operation
Channel buffering:
- Each channel has a 1-entry holding register with a `pend[i]` flag.
- `wr_req_val[i]` with `pend[i]`=0: capture the data and set `pend[i]`.
- `wr_req_val[i]` with `pend[i]`=1 and channel i not granted this cycle: the new record is dropped and `drop_cnt` increments.
- If channel i is granted in the same cycle, the new record is captured, because the slot frees that cycle.

Arbitration and writes:
- Round-robin arbiter over `pend`; at most one grant per cycle.
- Priority rotates to the channel after the last granted one.
- On a grant, write `{i, hold[i]}` to `mem[curr_wr_addr]`, clear `pend[i]` and increment `curr_wr_addr` modulo the depth.
- When `curr_wr_addr` goes from the last index to 0: set `log_has_wrapped`. If WRAP_MODE=0, also set `log_full`.
- While `log_full`=1: no grants, `pend` is held, and new writes to pending channels count as drops.

Drop accounting:
- Multiple drops in one cycle add the popcount of the dropped channels.
- `drop_cnt` saturates at 0xFFFF_FFFF.

Clear (`log_clr`):
- On the next edge: `curr_wr_addr`=0, `log_has_wrapped`=0, `log_full`=0, all `pend`=0, `drop_cnt`=0, arbiter pointer=0.
- Any write arriving in the same cycle as `log_clr` is discarded and not counted.
- Memory contents are not cleared.

Reads:
- `rd_req_rdy = !rd_resp_val || rd_resp_rdy`.
- An accepted request performs a synchronous RAM read.
- `rd_resp_data` is held stable while `rd_resp_val && !rd_resp_rdy`; the RAM read enable is gated by acceptance.
- Read and write to the same address in the same cycle: the read returns the old data (read-first).
- An outstanding read response is delivered normally across a `log_clr`.

## Timing
- Reset values:
  - `rd_req_rdy`=1 (combinational from `rd_resp_val`=0).
  - `rd_resp_val`=0, `rd_resp_data`=0.
  - `curr_wr_addr`=0, `log_has_wrapped`=0, `log_full`=0, `drop_cnt`=0.
  - All `pend`=0; arbiter pointer=0.
- Write path:
  - Record captured at edge t.
  - Earliest grant in cycle t+1; memory written at edge t+1.
  - `curr_wr_addr` updates at edge t+1.
  - The entry is readable by a request issued in cycle t+2 or later.
- Throughput: 1 record/cycle aggregate. With all channels busy, each channel is granted at least once every `NUM_CH` cycles.
- Read latency: request accepted at edge t; `rd_resp_val`=1 in cycle t+1.
- Read throughput: back-to-back reads at 1 per cycle while `rd_resp_rdy`=1.
- Reset mid-operation discards pending records and any read in flight.

## Structure
- Shared package `multi_ch_log_pkg` holds:
  - `log_entry_struct`: `ch_id` plus `record`, packed.
  - the `CH_W` function.
  - the `DROP_CNT_W`=32 constant.
- Sub-modules:
  - `rr_arbiter`: parametrised `NUM_CH`; inputs request vector and advance; outputs one-hot grant and grant index.
  - Memory: the existing simple dual-port synchronous RAM, instantiated with `ENTRY_W` × depth.
- Holding registers, pointers and counters stay in the top module.

## Test plan
- **Single channel:** NUM_CH=4, depth 16. Write 0xA5 on channel 2 in cycle 0. Expect `curr_wr_addr`=1 after edge 1. Reading addr 0 in cycle 2 returns `{2, 0xA5}`.
- **All channels, same cycle:** all 4 channels write in one cycle. Expect entries 0..3 tagged with channels 0,1,2,3 in order. A second simultaneous burst is ordered 0,1,2,3 again, starting after the last grant, channel 3. `drop_cnt`=0.
- **Back-to-back on one channel:** channel 1 writes while channels 0,2,3 stay pending for 4 cycles. Expect `drop_cnt`=2, and channel 1's data in the log to be the 1st and 4th records.
- **Wrap mode:** WRAP_MODE=1, depth 16, 18 writes. Expect `log_has_wrapped`=1, `curr_wr_addr`=2, entry 0 = record 16, `log_full`=0.
- **Stop mode:** WRAP_MODE=0, depth 16, 20 writes on channel 0 only. Expect `log_full`=1 and `curr_wr_addr`=0. Records 17..20: the first stays held in `pend[0]`; `drop_cnt`=3; entry 0 = record 1. Then `log_clr` gives all flags and counters 0.
- **Read backpressure:** hold `rd_resp_rdy`=0 for 5 cycles after a read. Expect `rd_req_rdy`=0 and `rd_resp_data` stable throughout. Release and issue 3 back-to-back reads: responses arrive on 3 consecutive cycles.
